au4_spe_ctrl: RTL and testbench

Sequencing controller for the AU-4 payload path, placed directly after the STM-1 pointer interpreter. It keeps a row and column flywheel over the 9×270 STM-1 byte grid and adopts the interpreted pointer at a fixed frame point. From these it generates the VC-4 byte-enable (`spe_en`) and the J1 marker (`j1`) for the downstream VC-4 extractor and elastic store. On positive and negative justification it removes or inserts the three justification bytes, and it squelches the payload while the pointer interpreter reports LOP or AIS.

---
 rtl/au4_spe_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_au4_spe_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/au4_spe_ctrl.sv
// AU-4 payload sequencing controller: STM-1 row/col flywheel, pointer adoption at the FSP,
// VC-4 byte enable and J1 marker. Macro AU4SPE_JUST_CNT_EN adds justification counters.
module au4_spe_ctrl #(
    parameter int MAXPTR = 782,
    parameter int INIT   = 0
) (
    input  logic        clk19,
    input  logic        rst,
    input  logic        en,
    input  logic        rxsof,
    input  logic [9:0]  ptr,
    input  logic        ptrvld,
    input  logic        inc,
    input  logic        dec,
    input  logic        lop,
    input  logic        ais,
`ifdef AU4SPE_JUST_CNT_EN
    input  logic        cnt_clr,
    output logic [15:0] inc_cnt,
    output logic [15:0] dec_cnt,
`endif
    output logic        spe_en,
    output logic        j1,
    output logic [3:0]  row,
    output logic [8:0]  col,
    output logic [9:0]  act_ptr,
    output logic        alarm
);

    typedef enum logic [1:0] {HUNT, RUN, ALARM} state_t;

    localparam logic [9:0] MAX_PTR = 10'(MAXPTR);

    state_t      state, state_d;
    logic [3:0]  cur_row;
    logic [8:0]  cur_col;
    logic [11:0] row_base, pos, ptr3;
    logic [9:0]  pend_ptr, eff_ptr;
    logic        pend_v, pend_inc, pend_dec, inc_frame;
    logic        fsp_loc, fsp, payload_loc, h3_loc, stuff_loc, inc_stuff;
    logic        do_inc, do_dec, exit_ok, run_now;
    logic        spe_en_d, j1_d, alarm_d;

    // Position of the byte being strobed now; row/col registers hold the previous byte.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        cur_row = row;
        cur_col = col;
        if (rxsof) begin
            cur_row = '0;
            cur_col = '0;
        end else if (col == 9'd269) begin
            cur_col = '0;
            cur_row = (row == 4'd8) ? 4'd0 : row + 4'd1;
        end else begin
            cur_col = col + 9'd1;
        end
    end

    // Payload offset of each row relative to the FSP row (row 3), in steps of 261.
    always_comb begin
        case (cur_row)
            4'd3:    row_base = 12'd0;
            4'd4:    row_base = 12'd261;
            4'd5:    row_base = 12'd522;
            4'd6:    row_base = 12'd783;
            4'd7:    row_base = 12'd1044;
            4'd8:    row_base = 12'd1305;
            4'd0:    row_base = 12'd1566;
            4'd1:    row_base = 12'd1827;
            4'd2:    row_base = 12'd2088;
            default: row_base = 12'd0;
        endcase
    end

    assign pos         = row_base + {3'b000, cur_col} - 12'd9;
    assign fsp_loc     = (cur_row == 4'd3) && (cur_col == 9'd9);
    assign fsp         = en && fsp_loc;
    assign payload_loc = cur_col >= 9'd9;
    assign h3_loc      = (cur_row == 4'd3) && (cur_col >= 9'd6) && (cur_col <= 9'd8);
    assign stuff_loc   = (cur_row == 4'd3) && (cur_col >= 9'd9) && (cur_col <= 9'd11);
    assign do_inc      = pend_inc && !pend_dec;
    assign do_dec      = pend_dec && !pend_inc;
    // The FSP byte itself decides on the live pending flag; cols 10..11 use the frame flag.
    assign inc_stuff   = stuff_loc && (fsp_loc ? do_inc : inc_frame);
    assign eff_ptr     = (fsp && pend_v) ? pend_ptr : act_ptr;
    assign ptr3        = {2'b00, eff_ptr} + {1'b0, eff_ptr, 1'b0};
    assign exit_ok     = (state == ALARM) && fsp && !lop && !ais && pend_v;
    assign run_now     = (state == RUN) || exit_ok;

    always_comb begin
        state_d  = state;
        spe_en_d = 1'b0;
        alarm_d  = 1'b0;
        unique case (state)
            HUNT:  if (en && rxsof) state_d = RUN;
            RUN:   if (lop || ais) state_d = ALARM;
            ALARM: begin
                alarm_d = !exit_ok;
                if (exit_ok) state_d = RUN;
            end
            default: state_d = HUNT;
        endcase
        if (en && run_now)
            spe_en_d = (payload_loc && !inc_stuff) || (h3_loc && do_dec);
        j1_d = spe_en_d && payload_loc && (pos == ptr3);
    end

    always_ff @(posedge clk19 or posedge rst) begin
        if (rst) state <= HUNT;
        else     state <= state_d;
    end

    always_ff @(posedge clk19 or posedge rst) begin
        if (rst) begin
            row       <= 4'(INIT);
            col       <= 9'(INIT);
            spe_en    <= 1'(INIT);
            j1        <= 1'(INIT);
            alarm     <= 1'(INIT);
            act_ptr   <= 10'(INIT);
            inc_frame <= 1'(INIT);
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            spe_en <= spe_en_d;
            j1     <= j1_d;
            alarm  <= alarm_d;
            if (en) begin
                row <= cur_row;
                col <= cur_col;
            end
            if (fsp) inc_frame <= run_now && do_inc;
            if (fsp && run_now && pend_v) act_ptr <= pend_ptr;
        end
    end

    // A strobe landing on the FSP byte itself survives the clear and waits for the next FSP.
    always_ff @(posedge clk19 or posedge rst) begin
        if (rst) begin
            pend_ptr <= 10'(INIT);
            pend_v   <= 1'(INIT);
            pend_inc <= 1'(INIT);
            pend_dec <= 1'(INIT);
        end else begin
            if (fsp && state != HUNT) begin
                pend_v   <= 1'b0;
                pend_inc <= 1'b0;
                pend_dec <= 1'b0;
            end
            if (state == ALARM) begin
                pend_inc <= 1'b0;
                pend_dec <= 1'b0;
            end
            if (ptrvld && ptr <= MAX_PTR) begin
                pend_ptr <= ptr;
                pend_v   <= 1'b1;
            end
            if (inc && state != ALARM) pend_inc <= 1'b1;
            if (dec && state != ALARM) pend_dec <= 1'b1;
        end
    end

`ifdef AU4SPE_JUST_CNT_EN
    logic just_inc, just_dec;

    assign just_inc = fsp && run_now && do_inc;
    assign just_dec = fsp && run_now && do_dec;

    always_ff @(posedge clk19 or posedge rst) begin
        if (rst) begin
            inc_cnt <= 16'(INIT);
            dec_cnt <= 16'(INIT);
        end else if (cnt_clr) begin
            inc_cnt <= '0;
            dec_cnt <= '0;
        end else begin
            if (just_inc && inc_cnt != 16'hFFFF) inc_cnt <= inc_cnt + 16'd1;
            if (just_dec && dec_cnt != 16'hFFFF) dec_cnt <= dec_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_au4_spe_ctrl.sv
// Directed bench for au4_spe_ctrl: whole STM-1 frames driven byte by byte with hand-computed
// expectations for J1 location, payload byte counts, justification, alarm and resync.
module tb_au4_spe_ctrl;

    localparam int FRAME = 2430;

    logic        clk19 = 1'b0;
    logic        rst, en, rxsof, ptrvld, inc, dec, lop, ais;
    logic [9:0]  ptr;
    logic        spe_en, j1, alarm;
    logic [3:0]  row;
    logic [8:0]  col;
    logic [9:0]  act_ptr;
`ifdef AU4SPE_JUST_CNT_EN
    logic        cnt_clr;
    logic [15:0] inc_cnt, dec_cnt;
`endif

    int total = 0;
    int bad   = 0;
    bit spe_map [0:FRAME-1];
    bit alarm_map [0:FRAME-1];
    int spe_cnt, poh_spe, j1_cnt, j1_first, j1_last, alarm_cnt;
    int grid_err = 0;
    int j1_orphan = 0;
    int rs_row, rs_col, exp_row, exp_col;

    au4_spe_ctrl dut (
        .clk19   (clk19),
        .rst     (rst),
        .en      (en),
        .rxsof   (rxsof),
        .ptr     (ptr),
        .ptrvld  (ptrvld),
        .inc     (inc),
        .dec     (dec),
        .lop     (lop),
        .ais     (ais),
`ifdef AU4SPE_JUST_CNT_EN
        .cnt_clr (cnt_clr),
        .inc_cnt (inc_cnt),
        .dec_cnt (dec_cnt),
`endif
        .spe_en  (spe_en),
        .j1      (j1),
        .row     (row),
        .col     (col),
        .act_ptr (act_ptr),
        .alarm   (alarm)
    );

    always #5 clk19 = ~clk19;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Free-running bytes without rxsof; tallies what the DUT reports.
    task automatic run_bytes(input int n, input logic lop_lvl);
        spe_cnt = 0; alarm_cnt = 0; j1_cnt = 0;
        for (int k = 0; k < n; k++) begin
            en = 1'b1; rxsof = 1'b0; lop = lop_lvl;
            @(posedge clk19); #1;
            if (spe_en === 1'b1) spe_cnt++;
            if (alarm === 1'b1) alarm_cnt++;
            if (j1 === 1'b1) j1_cnt++;
        end
        lop = 1'b0;
    endtask

    // One 9x270 frame starting with rxsof; optional strobe, lop window and mid-frame resync.
    task automatic send_frame(input int s_idx, input logic [9:0] s_ptr, input bit s_pv,
                              input bit s_inc, input bit s_dec, input int lop_on,
                              input int lop_off, input int rs_idx);
        spe_cnt = 0; poh_spe = 0; j1_cnt = 0; j1_first = -1; j1_last = -1;
        for (int k = 0; k < FRAME; k++) begin
            en     = 1'b1;
            rxsof  = (k == 0) || (k == rs_idx);
            ptr    = s_ptr;
            ptrvld = s_pv && (k == s_idx);
            inc    = s_inc && (k == s_idx);
            dec    = s_dec && (k == s_idx);
            lop    = (k >= lop_on) && (k < lop_off);
            @(posedge clk19); #1;
            if (rxsof) begin
                exp_row = 0; exp_col = 0;
            end else if (exp_col == 269) begin
                exp_col = 0; exp_row = (exp_row == 8) ? 0 : exp_row + 1;
            end else begin
                exp_col++;
            end
            if (row !== 4'(exp_row) || col !== 9'(exp_col)) grid_err++;
            spe_map[k]   = (spe_en === 1'b1);
            alarm_map[k] = (alarm === 1'b1);
            if (spe_en === 1'b1) begin
                spe_cnt++;
                if (exp_col < 9) poh_spe++;
            end
            if (j1 === 1'b1) begin
                j1_cnt++;
                if (j1_first < 0) j1_first = k;
                j1_last = k;
                if (spe_en !== 1'b1) j1_orphan++;
            end
            if (k == rs_idx) begin
                rs_row = int'(row); rs_col = int'(col);
            end
        end
        rxsof = 1'b0; ptrvld = 1'b0; inc = 1'b0; dec = 1'b0; lop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; rxsof = 1'b0; ptr = '0; ptrvld = 1'b0;
        inc = 1'b0; dec = 1'b0; lop = 1'b0; ais = 1'b0;
        exp_row = 0; exp_col = 0; rs_row = -1; rs_col = -1;
`ifdef AU4SPE_JUST_CNT_EN
        cnt_clr = 1'b0;
`endif
        #23;
        check("rst_spe_en", spe_en, 0);
        check("rst_j1", j1, 0);
        check("rst_row", row, 0);
        check("rst_col", col, 0);
        check("rst_act_ptr", act_ptr, 0);
        check("rst_alarm", alarm, 0);
        rst = 1'b0;

        run_bytes(300, 1'b0);
        check("hunt_spe_cnt", spe_cnt, 0);

        // Normal frame, ptr 0: J1 at row 3 col 9 (index 819)
        send_frame(100, 10'd0, 1, 0, 0, -1, -1, -1);
        check("f1_spe_cnt", spe_cnt, 2349);
        check("f1_poh_spe", poh_spe, 0);
        check("f1_j1_cnt", j1_cnt, 1);
        check("f1_j1_idx", j1_first, 819);

        // Pointer 522 adopted at this FSP; J1 lands at row 0 col 9 of the next frame
        send_frame(100, 10'd522, 1, 0, 0, -1, -1, -1);
        check("f2_j1_cnt", j1_cnt, 0);
        check("f2_act_ptr", act_ptr, 522);

        // Out-of-range pointer 800 is ignored
        send_frame(100, 10'd800, 1, 0, 0, -1, -1, -1);
        check("f3_j1_cnt", j1_cnt, 1);
        check("f3_j1_idx", j1_first, 9);
        check("f3_act_ptr", act_ptr, 522);

        en = 1'b0;
        repeat (2) begin
            @(posedge clk19); #1;
        end
        check("idle_spe_en", spe_en, 0);
        check("idle_row", row, 8);
        check("idle_col", col, 269);

        // Positive justification with ptr 1 strobed together
        send_frame(100, 10'd1, 1, 1, 0, -1, -1, -1);
        check("inc_spe_cnt", spe_cnt, 2346);
        check("inc_stuff_c9", spe_map[819], 0);
        check("inc_stuff_c11", spe_map[821], 0);
        check("inc_data_c12", spe_map[822], 1);
        check("inc_j1_cnt", j1_cnt, 2);
        check("inc_j1_old", j1_first, 9);
        check("inc_j1_new", j1_last, 822);

        // Negative justification: H3 bytes carry data
        send_frame(100, 10'd0, 0, 0, 1, -1, -1, -1);
        check("dec_spe_cnt", spe_cnt, 2352);
        check("dec_h3_c6", spe_map[816], 1);
        check("dec_h3_c8", spe_map[818], 1);
        check("dec_j1_idx", j1_first, 822);
`ifdef AU4SPE_JUST_CNT_EN
        check("cnt_inc_1", inc_cnt, 1);
        check("cnt_dec_1", dec_cnt, 1);
`endif

        // Simultaneous inc + dec: discarded
        send_frame(100, 10'd0, 0, 1, 1, -1, -1, -1);
        check("both_spe_cnt", spe_cnt, 2349);
        check("both_h3", spe_map[816], 0);
        check("both_c9", spe_map[819], 1);
`ifdef AU4SPE_JUST_CNT_EN
        check("cnt_inc_both", inc_cnt, 1);
        check("cnt_dec_both", dec_cnt, 1);
`endif

        // LOP from byte 1000 to 1499, ptr 100 strobed at byte 1600
        send_frame(1600, 10'd100, 1, 0, 0, 1000, 1500, -1);
        check("lop_last_spe", spe_map[1000], 1);
        check("lop_last_alarm", alarm_map[1000], 0);
        check("lop_squelch", spe_map[1001], 0);
        check("lop_alarm", alarm_map[1001], 1);
        check("lop_spe_cnt", spe_cnt, 965);
        check("lop_alarm_tail", alarm_map[2429], 1);

        // Recovery at the next FSP with ptr 100: J1 at pos 300 = row 4 col 48
        send_frame(-1, 10'd0, 0, 0, 0, -1, -1, -1);
        check("rec_row2_sq", spe_map[640], 0);
        check("rec_alarm_pre", alarm_map[818], 1);
        check("rec_alarm_fsp", alarm_map[819], 0);
        check("rec_spe_fsp", spe_map[819], 1);
        check("rec_spe_cnt", spe_cnt, 1566);
        check("rec_j1_idx", j1_first, 1128);
        check("rec_act_ptr", act_ptr, 100);

        // rxsof at row 5 col 40
        send_frame(-1, 10'd0, 0, 0, 0, -1, -1, 1390);
        check("resync_row", rs_row, 0);
        check("resync_col", rs_col, 0);

        // Asynchronous reset mid-frame
        run_bytes(50, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_spe_en", spe_en, 0);
        check("arst_row", row, 0);
        check("arst_col", col, 0);
        check("arst_act_ptr", act_ptr, 0);
        check("arst_alarm", alarm, 0);
        @(posedge clk19);
        #3;
        rst = 1'b0;
        run_bytes(300, 1'b1);
        check("arst_hunt_spe", spe_cnt, 0);
        check("arst_hunt_alarm", alarm_cnt, 0);
`ifdef AU4SPE_JUST_CNT_EN
        check("arst_inc_cnt", inc_cnt, 0);
`endif

        // Three inc frames with ptr 0: J1 would sit on a stuff byte, so none appears
        send_frame(100, 10'd0, 0, 1, 0, -1, -1, -1);
        check("inc0_spe_cnt", spe_cnt, 2346);
        check("inc0_j1_cnt", j1_cnt, 0);
        send_frame(100, 10'd0, 0, 1, 0, -1, -1, -1);
        send_frame(100, 10'd0, 0, 1, 0, -1, -1, -1);
`ifdef AU4SPE_JUST_CNT_EN
        check("cnt_inc_3", inc_cnt, 3);
        check("cnt_dec_0", dec_cnt, 0);
        en = 1'b0;
        cnt_clr = 1'b1;
        @(posedge clk19); #1;
        cnt_clr = 1'b0;
        check("cnt_clr_inc", inc_cnt, 0);
`endif

        check("grid_errors", grid_err, 0);
        check("j1_without_spe", j1_orphan, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
